// File: rtl/instruction_fetch.sv
// Fetch stage of the RV32 core: owns the PC, addresses the combinational
// instruction memory and fills the IF/ID register. Handles stall, flush, redirect, halt and fault.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1280,
  parameter logic [31:0] NOP        = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

  state_t      state;
  logic [31:0] pc_p0;
  logic        vld_p1;
  logic [31:0] ifid_pc_p1;
  logic [31:0] ifid_instr_p1;
  logic [31:0] count;

  // Stage p0: PC addresses memory combinationally
  assign imem_addr = {2'b00, pc_p0[31:2]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= RUN;
      pc_p0         <= {RESET_PC[31:2], 2'b00};
      vld_p1        <= 1'b0;
      ifid_pc_p1    <= '0;
      ifid_instr_p1 <= NOP;
      count         <= '0;
    end else if (redirect_valid) begin
      state         <= RUN;
      pc_p0         <= {redirect_pc[31:2], 2'b00};
      vld_p1        <= 1'b0;
      ifid_pc_p1    <= '0;
      ifid_instr_p1 <= NOP;
    end else if (state != RUN) begin
      vld_p1        <= 1'b0;
      ifid_pc_p1    <= '0;
      ifid_instr_p1 <= NOP;
    end else if (pc_p0[31:2] >= IMEM_LIMIT) begin
      // Out-of-range PC faults even when stalled; PC stays put for debug.
      state         <= FAULT;
      vld_p1        <= 1'b0;
      ifid_pc_p1    <= '0;
      ifid_instr_p1 <= NOP;
    end else if (stall) begin
      if (flush) begin
        vld_p1        <= 1'b0;
        ifid_pc_p1    <= '0;
        ifid_instr_p1 <= NOP;
      end
    end else if (imem_instr == 32'h0000_0000) begin
      // An unprogrammed word marks the end of the program.
      state         <= HALT;
      vld_p1        <= 1'b0;
      ifid_pc_p1    <= '0;
      ifid_instr_p1 <= NOP;
    end else if (flush) begin
      pc_p0         <= pc_p0 + 32'd4;
      vld_p1        <= 1'b0;
      ifid_pc_p1    <= '0;
      ifid_instr_p1 <= NOP;
    end else begin
      pc_p0         <= pc_p0 + 32'd4;
      vld_p1        <= 1'b1;
      ifid_pc_p1    <= pc_p0;
      ifid_instr_p1 <= imem_instr;
      count         <= count + 32'd1;
    end
  end

  // Stage p1: IF/ID register drives decode
  assign ifid_valid  = vld_p1;
  assign ifid_pc     = ifid_pc_p1;
  assign ifid_instr  = ifid_instr_p1;
  assign halted      = (state == HALT);
  assign fault       = (state == FAULT);
  assign fetch_count = count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a spec-level reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_instruction_fetch;

  localparam int WORDS = 1280;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, redirect_valid;
  logic [31:0] redirect_pc, imem_addr, imem_instr;
  logic        ifid_valid, halted, fault;
  logic [31:0] ifid_pc, ifid_instr, fetch_count;

  logic [31:0] mem [0:WORDS-1];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr < WORDS) ? mem[imem_addr[10:0]] : 32'h0;

  instruction_fetch #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS), .NOP(NOPW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
    .halted(halted), .fault(fault), .fetch_count(fetch_count)
  );

  // Reference model: whole-stage behaviour written as plain rules over integers.
  bit          m_init = 0;
  int          m_mode;            // 0 running, 1 halted, 2 faulted
  logic [31:0] m_pc, m_ifpc, m_instr, m_count;
  bit          m_valid;

  function automatic logic [31:0] word_at(input logic [31:0] byte_addr);
    longint idx = longint'(byte_addr) / 4;
    return (idx < WORDS) ? mem[int'(idx)] : 32'h0;
  endfunction

  task automatic m_bubble();
    m_valid = 0; m_ifpc = 0; m_instr = NOPW;
  endtask

  always @(posedge clk) begin
    logic [31:0] w;
    if (!rst_n) begin
      m_init = 1; m_mode = 0; m_pc = 0; m_count = 0; m_bubble();
    end else if (m_init) begin
      if (redirect_valid) begin
        m_pc = redirect_pc & 32'hFFFF_FFFC; m_mode = 0; m_bubble();
      end else if (m_mode != 0) begin
        m_bubble();
      end else if (longint'(m_pc) / 4 >= WORDS) begin
        m_mode = 2; m_bubble();
      end else if (stall) begin
        if (flush) m_bubble();
      end else begin
        w = word_at(m_pc);
        if (w == 0) begin
          m_mode = 1; m_bubble();
        end else if (flush) begin
          m_pc = m_pc + 4; m_bubble();
        end else begin
          m_valid = 1; m_ifpc = m_pc; m_instr = w;
          m_pc = m_pc + 4; m_count = m_count + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      check("cmp_valid",  {31'b0, ifid_valid}, {31'b0, m_valid});
      check("cmp_pc",     ifid_pc, m_ifpc);
      check("cmp_instr",  ifid_instr, m_instr);
      check("cmp_count",  fetch_count, m_count);
      check("cmp_halted", {31'b0, halted}, {31'b0, m_mode == 1});
      check("cmp_fault",  {31'b0, fault}, {31'b0, m_mode == 2});
      check("cmp_addr",   imem_addr, m_pc >> 2);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = (i < 12) ? 32'h1000_0000 + i : 32'h0;
    rst_n = 0; stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0;
    step(); step();
    check("rst_valid", {31'b0, ifid_valid}, 32'd0);
    check("rst_instr", ifid_instr, 32'h0000_0013);
    check("rst_count", fetch_count, 32'd0);
    check("rst_addr",  imem_addr, 32'd0);

    // Straight-line run to halt
    rst_n = 1;
    step();
    check("first_valid", {31'b0, ifid_valid}, 32'd1);
    check("first_instr", ifid_instr, 32'h1000_0000);
    for (int i = 1; i < 12; i++) begin
      step();
      check("run_pc", ifid_pc, 32'(i * 4));
    end
    step();
    check("halt_flag",  {31'b0, halted}, 32'd1);
    check("halt_valid", {31'b0, ifid_valid}, 32'd0);
    check("halt_count", fetch_count, 32'd12);
    check("halt_addr",  imem_addr, 32'd12);
    step();
    check("halt_hold", imem_addr, 32'd12);

    // Halt recovery
    redirect_valid = 1; redirect_pc = 32'h0;
    step();
    redirect_valid = 0;
    check("unhalt", {31'b0, halted}, 32'd0);
    step();
    check("restart_pc",    ifid_pc, 32'd0);
    check("restart_count", fetch_count, 32'd13);
    step(); step();
    check("pre_stall_pc", ifid_pc, 32'd8);

    // Stall for 3 cycles
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc",    ifid_pc, 32'd8);
      check("stall_instr", ifid_instr, 32'h1000_0002);
      check("stall_count", fetch_count, 32'd15);
    end
    stall = 0;
    step();
    check("post_stall_pc", ifid_pc, 32'd12);

    // Redirect while fetching pc 16
    check("redir_from", imem_addr, 32'd4);
    redirect_valid = 1; redirect_pc = 32'h0000_0019;
    step();
    redirect_valid = 0;
    check("redir_bubble", ifid_instr, 32'h0000_0013);
    step();
    check("redir_pc",    ifid_pc, 32'd24);
    check("redir_instr", ifid_instr, 32'h1000_0006);

    // Redirect beats stall
    redirect_valid = 1; redirect_pc = 32'h4; stall = 1;
    step();
    redirect_valid = 0; stall = 0;
    check("redir_stall_addr", imem_addr, 32'd1);
    step();
    check("redir_stall_pc", ifid_pc, 32'd4);

    // Flush discards the fetched word; flush with stall bubbles but holds PC
    flush = 1;
    step();
    flush = 0;
    check("flush_valid", {31'b0, ifid_valid}, 32'd0);
    check("flush_addr",  imem_addr, 32'd3);
    step();
    check("flush_next_pc", ifid_pc, 32'd12);
    stall = 1; flush = 1;
    step();
    stall = 0; flush = 0;
    check("sflush_valid", {31'b0, ifid_valid}, 32'd0);
    check("sflush_addr",  imem_addr, 32'd4);

    // Fault on out-of-range PC
    redirect_valid = 1; redirect_pc = 32'd5120;
    step();
    redirect_valid = 0;
    step();
    check("fault_flag",  {31'b0, fault}, 32'd1);
    check("fault_valid", {31'b0, ifid_valid}, 32'd0);
    check("fault_addr",  imem_addr, 32'd1280);
    stall = 1;
    step();
    stall = 0;
    check("fault_hold", {31'b0, fault}, 32'd1);
    redirect_valid = 1; redirect_pc = 32'h0;
    step();
    redirect_valid = 0;
    check("unfault", {31'b0, fault}, 32'd0);
    step();
    check("unfault_pc", ifid_pc, 32'd0);

    // Mid-run reset at pc 20
    for (int i = 0; i < 4; i++) step();
    check("pre_rst_addr", imem_addr, 32'd5);
    rst_n = 0;
    step();
    check("mid_rst_valid", {31'b0, ifid_valid}, 32'd0);
    check("mid_rst_count", fetch_count, 32'd0);
    check("mid_rst_addr",  imem_addr, 32'd0);
    rst_n = 1;
    step();
    check("mid_rst_pc",    ifid_pc, 32'd0);
    check("mid_rst_cnt1",  fetch_count, 32'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
